// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with one outstanding imem request
// Single-entry output register to decode; redirects flush any in-flight response.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        load;
  logic [31:0] redirect_pc_al;

  assign redirect_pc_al = redirect_pc & ALIGN_MASK;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    imem_req     = 1'b0;
    load         = 1'b0;
    imem_addr    = pc_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req = !inst_valid_q || id_ready;
        if (imem_req) begin
          addr_d = pc_q;
          if (imem_ack) begin
            load = !redirect;
          end else begin
            state_d = redirect ? FLUSH : WAIT;
          end
        end
      end
      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack) begin
          state_d = REQ;
          load    = !redirect;
        end else if (redirect) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Old request must still complete; its data is dropped.
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (inst_valid_q && id_ready) begin
      inst_valid_d = 1'b0;
    end
    if (load) begin
      inst_d       = imem_rdata;
      inst_pc_d    = imem_addr;
      inst_valid_d = 1'b1;
      pc_d         = imem_addr + 32'd4;
    end
    // Redirect overrides any load or transfer in the same cycle.
    if (redirect) begin
      pc_d         = redirect_pc_al;
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC_AL;
      addr_q       <= RESET_PC_AL;
      inst_q       <= NOP;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_valid_q ? inst_q : NOP;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  inst_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic exp_fetch(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic exp_inst(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] word);
    chk({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, v});
    if (v) begin
      chk({tag, ".pc"}, inst_pc, pc);
      chk({tag, ".inst"}, inst, word);
    end else begin
      chk({tag, ".nop"}, inst, NOP);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic redir,
                       input logic [31:0] rpc, input logic rdy);
    imem_ack    = ack;
    imem_rdata  = rdata;
    redirect    = redir;
    redirect_pc = rpc;
    id_ready    = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step();
    step();
    exp_fetch("rst", 1'b0, 32'h0);
    exp_inst("rst", 1'b0, 32'h0, NOP);
    chk("rst.inst_pc", inst_pc, 32'h0);

    // Release reset: one IDLE cycle in which an ack must be ignored.
    rst_n = 1'b1;
    drive(1'b1, 32'hEEEE_EEEE, 1'b0, 32'h0, 1'b1);
    exp_fetch("idle", 1'b0, 32'h0);
    step();

    // Zero-latency ack, decode always ready: one instruction per cycle.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hA000_0000 | (k * 4), 1'b0, 32'h0, 1'b1);
      exp_fetch($sformatf("tput%0d", k), 1'b1, k * 4);
      if (k == 0) exp_inst("tput0", 1'b0, 32'h0, NOP);
      else exp_inst($sformatf("tput%0d", k), 1'b1, (k - 1) * 4, 32'hA000_0000 | ((k - 1) * 4));
      step();
    end

    // Decode stall: output held, no request, pc frozen.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp_fetch($sformatf("stall%0d", k), 1'b0, 32'h10);
      exp_inst($sformatf("stall%0d", k), 1'b1, 32'hC, 32'hA000_000C);
      step();
    end

    // Three-cycle ack latency.
    for (int j = 0; j < 2; j++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      exp_fetch($sformatf("lat%0d.c0", j), 1'b1, 32'h10 + j * 4);
      chk($sformatf("lat%0d.c0.valid", j), {31'b0, inst_valid}, 32'h1);
      step();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      exp_fetch($sformatf("lat%0d.c1", j), 1'b1, 32'h10 + j * 4);
      exp_inst($sformatf("lat%0d.c1", j), 1'b0, 32'h0, NOP);
      step();
      drive(1'b1, 32'hB000_0010 + j * 4, 1'b0, 32'h0, 1'b1);
      exp_fetch($sformatf("lat%0d.c2", j), 1'b1, 32'h10 + j * 4);
      step();
    end

    // Redirect during WAIT goes through FLUSH.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    exp_inst("wr.c0", 1'b1, 32'h14, 32'hB000_0014);
    exp_fetch("wr.c0", 1'b1, 32'h18);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b1);
    exp_fetch("wr.c1", 1'b1, 32'h18);
    step();
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    exp_fetch("wr.flush", 1'b1, 32'h18);
    exp_inst("wr.flush", 1'b0, 32'h0, NOP);
    step();
    drive(1'b1, 32'hC000_0100, 1'b0, 32'h0, 1'b1);
    exp_fetch("wr.tgt", 1'b1, 32'h100);
    exp_inst("wr.tgt", 1'b0, 32'h0, NOP);
    step();

    // Redirect with ack to the top of memory (low bits of the target dropped).
    drive(1'b1, 32'h1111_1111, 1'b1, 32'hFFFF_FFFF, 1'b1);
    exp_inst("wr.done", 1'b1, 32'h100, 32'hC000_0100);
    exp_fetch("wr.done", 1'b1, 32'h104);
    step();
    drive(1'b1, 32'h2222_2222, 1'b1, 32'h0000_0300, 1'b1);
    exp_fetch("top.redir", 1'b1, 32'hFFFF_FFFC);
    exp_inst("top.redir", 1'b0, 32'h0, NOP);
    step();
    drive(1'b1, 32'h3333_3333, 1'b1, 32'hFFFF_FFFC, 1'b1);
    exp_fetch("top.nowrap", 1'b1, 32'h300);
    exp_inst("top.nowrap", 1'b0, 32'h0, NOP);
    step();
    drive(1'b1, 32'hD000_0000, 1'b0, 32'h0, 1'b1);
    exp_fetch("top.fetch", 1'b1, 32'hFFFF_FFFC);
    step();

    // Wrap to zero, then two redirects before the next fetch: last wins.
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0400, 1'b1);
    exp_inst("wrap", 1'b1, 32'hFFFF_FFFC, 32'hD000_0000);
    exp_fetch("wrap", 1'b1, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0500, 1'b1);
    exp_fetch("last.f1", 1'b1, 32'h0);
    exp_inst("last.f1", 1'b0, 32'h0, NOP);
    step();
    drive(1'b1, 32'h4444_4444, 1'b0, 32'h0, 1'b1);
    exp_fetch("last.f2", 1'b1, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    exp_fetch("last.tgt", 1'b1, 32'h500);
    exp_inst("last.tgt", 1'b0, 32'h0, NOP);
    step();

    // Asynchronous reset during WAIT; late ack ignored.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    exp_fetch("ar.wait", 1'b1, 32'h500);
    rst_n = 1'b0;
    #1;
    exp_fetch("ar.async", 1'b0, 32'h0);
    exp_inst("ar.async", 1'b0, 32'h0, NOP);
    chk("ar.async.inst_pc", inst_pc, 32'h0);
    drive(1'b1, 32'h5555_5555, 1'b0, 32'h0, 1'b1);
    step();
    exp_fetch("ar.held", 1'b0, 32'h0);
    exp_inst("ar.held", 1'b0, 32'h0, NOP);
    rst_n = 1'b1;
    drive(1'b1, 32'h5555_5555, 1'b0, 32'h0, 1'b1);
    exp_fetch("ar.idle", 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    exp_fetch("ar.req", 1'b1, 32'h0);
    exp_inst("ar.req", 1'b0, 32'h0, NOP);
    step();
    drive(1'b1, 32'h6666_6666, 1'b0, 32'h0, 1'b1);
    exp_fetch("ar.wait2", 1'b1, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp_inst("ar.load", 1'b1, 32'h0, 32'h6666_6666);
    exp_fetch("ar.load", 1'b0, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ack  input  1  imem_rdata valid this cycle for the outstanding request.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 redirect  input  1  control-flow redirect from branch/jal/jalr resolution.
REQ-009 redirect_pc  input  32  redirect target address.
REQ-010 id_ready  input  1  decode stage accepts inst this cycle.
REQ-011 inst_valid  output  1  inst/inst_pc hold a valid instruction.
REQ-012 inst  output  32  instruction word to decode.
REQ-013 inst_pc  output  32  address of inst.

Function
REQ-014 The block SHALL keep at most one imem request outstanding.
REQ-015 The block SHALL hold imem_req high, with imem_addr stable, from assertion until the cycle imem_ack is sampled high; imem_ack may arrive in the same cycle as imem_req.
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT and FLUSH.
- IDLE: reset state; always moves to REQ on the next cycle.
- REQ: imem_req = (!inst_valid | id_ready).
- WAIT: request outstanding.
- FLUSH: request outstanding, response to be discarded.
REQ-017 REQ transitions SHALL be: with imem_req=1 and no ack, go to WAIT; with ack, stay in REQ; with imem_req=0, stay in REQ.
REQ-018 WAIT SHALL drive imem_req=1 regardless of id_ready, and return to REQ on ack.
REQ-019 An accepted, non-discarded ack SHALL load inst<=imem_rdata, inst_pc<=pc and inst_valid<=1, and advance pc<=pc+4.
- pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 (modulo 2^32).
REQ-020 The output transfer SHALL occur when inst_valid & id_ready.
- With no new load that cycle, inst_valid clears next cycle.
- inst and inst_pc hold their values while inst_valid=1 and id_ready=0.
REQ-021 Throughput SHALL be one instruction per cycle when imem_ack returns in the same cycle and id_ready stays high.
REQ-022 A redirect SHALL take priority over all other events.
- pc <= {redirect_pc[31:2],2'b00}.
- inst_valid <= 0 next cycle.
- Any ack in that cycle is discarded.
REQ-023 Redirect state handling SHALL be:
- Redirect in REQ with imem_req=1 and no ack, or in WAIT without ack: go to FLUSH.
- Redirect in WAIT with ack: go to REQ.
- Redirect in IDLE: go to REQ.
- Redirect in FLUSH: update pc only.
REQ-024 FLUSH SHALL hold imem_req and the old imem_addr until ack, discard imem_rdata, and then go to REQ with imem_addr equal to the redirect target.
REQ-025 When multiple redirects arrive before a new fetch is launched, the last redirect SHALL win.
REQ-026 imem_addr SHALL equal the outstanding-request address in WAIT/FLUSH and pc otherwise; imem_addr[1:0] SHALL always be 2'b00.
REQ-027 When inst_valid=0, inst SHALL read 32'h0000_0013 (NOP).

Reset
REQ-028 Assertion of rst_n=0 SHALL immediately force:
- state=IDLE
- pc=RESET_PC
- inst_valid=0
- imem_req=0
- inst=32'h0000_0013
- inst_pc=RESET_PC
REQ-029 The first imem_req SHALL assert in the second rising edge after rst_n deasserts (one IDLE cycle).
REQ-030 On reset assertion mid-transaction, the block SHALL abandon the outstanding request without waiting for ack; acks arriving during reset or in IDLE SHALL be ignored.

Verification
REQ-031 Reset release with ack tied high and id_ready=1 -> imem_addr 0,4,8,… on consecutive cycles; inst_valid high from cycle 2; inst_pc tracks the addresses.
REQ-032 Ack latency 3 cycles -> imem_req held 3 cycles with constant imem_addr; one instruction every 3 cycles.
REQ-033 id_ready=0 for 4 cycles with inst_valid=1 -> inst/inst_pc stable, imem_req=0, no pc advance; resumes at the next address once id_ready=1.
REQ-034 Redirect to 32'h0000_0102 during WAIT -> FLUSH, old response discarded, next imem_addr=32'h0000_0100, inst_valid=0 until its ack.
REQ-035 Redirect coinciding with ack at pc 32'hFFFF_FFFC -> data dropped, no wrap fetch, next imem_addr=target; separately without redirect, next address is 32'h0000_0000.
REQ-036 rst_n pulsed low during WAIT -> outputs reset asynchronously; late ack ignored; fetch restarts at RESET_PC.
